// File: rtl/led_scan_controller.sv
// led_scan_controller: column scan FSM with blanking, dwell and a
// double-buffered frame for the N x N LED array driver.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   ena          scan enable, low forces IDLE
//   frame_in     new frame, bit N*j+i is LED (i,j)
//   frame_valid  producer offers frame_in
//   frame_ready  pending buffer empty
//   brightness   dwell duty (only with LED_SCAN_BRIGHTNESS_EN)
//   cells        displayed frame to the driver
//   x            current column to the driver
//   drv_ena      driver enable
//   frame_done   pulse when the last column's dwell completes
//
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN
module led_scan_controller #(
    parameter int N            = 5,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ena,
    input  logic [N*N-1:0]               frame_in,
    input  logic                         frame_valid,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [$clog2(DWELL_CYCLES+1)-1:0] brightness,
`endif
    output logic                         frame_ready,
    output logic [N*N-1:0]               cells,
    output logic [$clog2(N)+1-1:0]       x,
    output logic                         drv_ena,
    output logic                         frame_done
);

    localparam int MAXC = (BLANK_CYCLES > DWELL_CYCLES) ?
                          BLANK_CYCLES : DWELL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int XW   = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DWELL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XW-1:0]   x_q, x_d;
    logic            drv_q, drv_d;
    logic            done_q, done_d;
    logic [N*N-1:0]  cells_q, cells_d;
    logic [N*N-1:0]  pend_q, pend_d;
    logic            full_q, full_d;
    logic            boundary;
    logic            xfer;

`ifdef LED_SCAN_BRIGHTNESS_EN
    localparam int BW = $clog2(DWELL_CYCLES + 1);
    logic [BW-1:0]   bri_q, bri_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        done_d   = 1'b0;
        boundary = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                x_d   = '0;
                if (ena) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (!ena) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DWELL: begin
                if (!ena) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    x_d     = '0;
                end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (x_q == XW'(N - 1)) begin
                        x_d      = '0;
                        done_d   = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                x_d     = '0;
            end
        endcase

        // swap needs a full buffer and capture needs an empty one,
        // so the two never coincide
        xfer    = frame_valid && !full_q;
        cells_d = cells_q;
        pend_d  = pend_q;
        full_d  = full_q;
        if (boundary && full_q) begin
            cells_d = pend_q;
            full_d  = 1'b0;
        end else if (xfer) begin
            pend_d = frame_in;
            full_d = 1'b1;
        end

        // enable is computed for the next cycle's state so that
        // drv_ena and x update on the same edge
`ifdef LED_SCAN_BRIGHTNESS_EN
        bri_d = bri_q;
        if (state_q == S_BLANK && state_d == S_DWELL)
            bri_d = brightness;
        drv_d = (state_d == S_DWELL) &&
                (32'(cnt_d) < 32'(bri_d));
`else
        drv_d = (state_d == S_DWELL);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            drv_q   <= 1'b0;
            done_q  <= 1'b0;
            cells_q <= '0;
            pend_q  <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            drv_q   <= drv_d;
            done_q  <= done_d;
            cells_q <= cells_d;
            pend_q  <= pend_d;
            full_q  <= full_d;
        end
    end

`ifdef LED_SCAN_BRIGHTNESS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bri_q <= '0;
        else      bri_q <= bri_d;
    end
`endif

    assign frame_ready = !full_q;
    assign cells       = cells_q;
    assign x           = x_q;
    assign drv_ena     = drv_q;
    assign frame_done  = done_q;

endmodule

// File: doc/led_scan_controller.md
# led_scan_controller

Time-multiplexing scan controller for the N×N LED array driver. It owns the column index `x` and the driver's `ena`, and steps through columns with a fixed blanking gap before each column's lit interval. It double-buffers the displayed frame so a new cell pattern is only applied at a frame boundary, which prevents tearing. It sits between the game-of-life state register (the producer) and the combinational `led_array_driver` (the consumer).

## Interface
- `N`, 5, array dimension; the driver is instantiated with ROWS=COLS=N.
- `DWELL_CYCLES`, 1000, clocks each column is lit; must be ≥1.
- `BLANK_CYCLES`, 16, clocks the driver is disabled before each column (anti-ghosting); must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  scan enable; low forces IDLE.
- `frame_in`  in  N*N  new frame; bit `N*j+i` is LED (i,j), same packing as the driver's `cells`.
- `frame_valid`  in  1  producer offers `frame_in`.
- `frame_ready`  out  1  pending buffer empty; a transfer happens when `frame_valid && frame_ready`.
- `cells`  out  N*N  displayed frame; connects to driver `cells`.
- `x`  out  $clog2(N)+1  current column; connects to driver `x`.
- `drv_ena`  out  1  connects to driver `ena`.
- `frame_done`  out  1  one-cycle pulse when the last column's dwell completes.

## Operation
- **States:** IDLE, BLANK, DWELL. A single counter `cnt` is shared by BLANK and DWELL.
- **IDLE:**
  - `drv_ena`=0, `x`=0, `cnt`=0.
  - If `ena`=1, go to BLANK on the next edge.
- **BLANK:**
  - `drv_ena`=0; `x` holds the upcoming column.
  - `cnt` counts 0..BLANK_CYCLES-1, then goes to DWELL with `cnt`=0.
- **DWELL:**
  - `drv_ena`=1 (subject to Configuration).
  - `cnt` counts 0..DWELL_CYCLES-1, then goes to BLANK with `cnt`=0.
  - If `x`<N-1, `x` increments. If `x`==N-1 (frame boundary), `x` wraps to 0 and `frame_done` pulses in that same cycle.
- **Frame swap:**
  - At each frame boundary, if the pending buffer is full: `cells` ← pending and pending is marked empty.
  - Otherwise `cells` holds its value.
- **Capture:**
  - A transfer writes `frame_in` into pending and marks it full; `frame_ready`=!full.
  - A transfer in the boundary cycle while pending is empty is not bypassed. It is displayed at the following boundary.
- **`ena` deassert in BLANK/DWELL:** next state is IDLE; `x`, `cnt` and `drv_ena` are cleared; `cells` and pending are retained; `frame_done` is not pulsed.
- **`ena` in IDLE:** the capture handshake still operates. The first frame after `ena` rises is displayed only after one full scan boundary. A frame accepted while `cells`=0 therefore appears after the first boundary.

## Timing
- **Reset values** (asynchronous, immediate): state=IDLE, `x`=0, `cnt`=0, `drv_ena`=0, `cells`=0, pending empty, `frame_ready`=1, `frame_done`=0.
- **All outputs are registered.** `drv_ena` and `x` change on the same edge, so there is no cycle where the driver is enabled with a stale `x`.
- **`ena` sampled high in IDLE at edge k:** BLANK for edges k+1..k+BLANK_CYCLES; `drv_ena`=1 from edge k+BLANK_CYCLES+1.
- **Column period** = BLANK_CYCLES+DWELL_CYCLES. **Frame period** = N·(BLANK_CYCLES+DWELL_CYCLES). There is no gap between frames.
- **`frame_ready` timing:** falls the cycle after a transfer and rises the cycle after a swap.
- **Counter width:** `cnt` is $clog2(max(BLANK_CYCLES,DWELL_CYCLES)+1) bits; comparisons are against `PARAM-1`, and the counter never wraps.

## Configuration
- **Macro:** `LED_SCAN_BRIGHTNESS_EN`.
- **Defined:**
  - Adds input port `brightness` with width $clog2(DWELL_CYCLES+1).
  - `brightness` is sampled on entry to DWELL and held for that column.
  - During DWELL, `drv_ena`=(`cnt` < sampled value). 0 means the LEDs are fully dark; ≥DWELL_CYCLES means full on.
  - State timing is unchanged.
- **Undefined:** no `brightness` port; `drv_ena`=1 for the whole of DWELL.

## Test plan
Parameters for all scenarios: N=5, DWELL_CYCLES=4, BLANK_CYCLES=2.
- **Reset mid-DWELL** (`x`=3): drop `rst` → `x`=0, `drv_ena`=0, `cells`=0 and `frame_ready`=1 immediately, without waiting for `clk`.
- **Scan sequence:** `ena`=1 held for 60 cycles → `x` sequence 0..4,0..4. Each column has 2 cycles `drv_ena`=0 then 4 cycles `drv_ena`=1. `frame_done` pulses at cycles 30 and 60 after the start.
- **Frame swap:** transfer `frame_in`=0x1FFFFFF at cycle 5 → `frame_ready` drops at cycle 6. `cells` stays 0 until the boundary, becomes 0x1FFFFFF there, and `frame_ready` rises the cycle after.
- **Back-pressure:** with pending full, hold `frame_valid` with 0x0000001 → no transfer. After the swap it transfers, and `cells`=0x0000001 at the next boundary.
- **`ena` drop during `x`=2 DWELL:** next cycle IDLE, `x`=0, `drv_ena`=0, no `frame_done`, `cells` unchanged.
- **Brightness** (`LED_SCAN_BRIGHTNESS_EN` defined): `brightness`=1 → exactly 1 `drv_ena` cycle per column. `brightness`=0 → `drv_ena` never high.
